// File: rtl/codec_i2s_tx.sv
// I2S transmitter: divides clk into BCLK/LRCLK and shifts one captured stereo pair per 32-slot frame.
// Capture to MSB on SDout is 2*BCLK_HALF clks; no backpressure (upstream advances on smpl_cap).
module codec_i2s_tx #(
  parameter int BCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] lft_in,
  input  logic [15:0] rht_in,
  output logic        smpl_cap,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        SDout
);

  localparam logic [7:0] DIV_MAX = 8'(BCLK_HALF - 1);

  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] sr;
  logic [4:0]  bit_nxt;
  logic        div_wrap;
  logic        fall_evt;

  assign bit_nxt  = bit_cnt + 5'd1;
  assign div_wrap = (div_cnt == DIV_MAX);
  // BCLK is about to go 1->0: the only cycle in which slot state advances
  assign fall_evt = div_wrap && BCLK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      BCLK     <= 1'b0;
      LRCLK    <= 1'b0;
      SDout    <= 1'b0;
      bit_cnt  <= 5'd31;
      sr       <= '0;
      smpl_cap <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      BCLK     <= 1'b0;
      LRCLK    <= 1'b0;
      SDout    <= 1'b0;
      bit_cnt  <= 5'd31;
      sr       <= '0;
      smpl_cap <= 1'b0;
    end else begin
      smpl_cap <= 1'b0;
      if (div_wrap) begin
        div_cnt <= '0;
        BCLK    <= ~BCLK;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        LRCLK   <= bit_nxt[4];
        SDout   <= sr[31];
        // slot 0 still emits the previous frame's rht LSB, so loading here is safe
        if (bit_nxt == 5'd0) begin
          sr       <= {lft_in, rht_in};
          smpl_cap <= 1'b1;
        end else begin
          sr <= {sr[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: doc/codec_i2s_tx.md
# codec_i2s_tx

Serial transmit stage for the audio datapath. Takes the scaled 16-bit left/right samples produced by the volume-scaling stage, captures one stereo pair per frame, and serializes them onto a standard I2S link (BCLK, LRCLK, SDout) toward the DAC codec. All link clocks are generated internally by dividing the system clock. A one-cycle capture strobe tells upstream logic when the current pair has been consumed.

## Interface

- BCLK_HALF, default 16: system clocks per BCLK half-period; legal range 2..255. BCLK = clk/(2*BCLK_HALF); frame rate = clk/(64*BCLK_HALF), 48.828 kHz at 50 MHz.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  link enable; low holds the block in its reset state (synchronous clear).
- lft_in  input  16  signed left sample (two's complement), sampled at frame start.
- rht_in  input  16  signed right sample, sampled at frame start.
- smpl_cap  output  1  one-clk pulse coincident with the capture of lft_in/rht_in.
- BCLK  output  1  I2S bit clock, registered.
- LRCLK  output  1  I2S word select: 0 = left, 1 = right; registered.
- SDout  output  1  I2S serial data, MSB first; registered.

## Operation

- Divider: div_cnt counts 0..BCLK_HALF-1. When it equals BCLK_HALF-1, BCLK toggles and div_cnt wraps to 0.
- A falling event is a cycle in which BCLK toggles 1->0. All data and LRCLK updates happen only on falling events, so the codec samples on BCLK rising edges with half a BCLK of setup.
- bit_cnt is 5 bits (slot 0..31) and increments on each falling event, wrapping 31->0.
- On each falling event, in order:
  - LRCLK <= new bit_cnt[4].
  - SDout <= sr[31].
  - sr <= sr<<1, except when new bit_cnt == 0: then sr <= {lft_in, rht_in} and smpl_cap = 1 for that clk.
- Resulting I2S framing (one-BCLK data delay):
  - Slot 0 carries rht LSB of the previous frame.
  - Slots 1..16 carry lft[15:0], MSB first.
  - Slot 16 is the first right slot (LRCLK = 1) and carries lft[0].
  - Slots 17..31 and next slot 0 carry rht[15:0].
- Captured data is held in sr. Changes on lft_in/rht_in between captures have no effect on the frame in flight.
- No arithmetic is performed. Bits pass through unmodified; sign is preserved by transmitting the MSB first.

## Timing

- Reset values (rst high, or en low at a clock edge):
  - div_cnt = 0, BCLK = 0, LRCLK = 0, SDout = 0.
  - bit_cnt = 31, sr = 0, smpl_cap = 0.
- After rst release with en = 1, counting clk edges from 1:
  - First BCLK rise is on edge BCLK_HALF.
  - First falling event is on edge 2*BCLK_HALF: bit_cnt -> 0, first capture, smpl_cap pulse.
- Subsequent captures come exactly every 64*BCLK_HALF clks. smpl_cap is never high for more than one clk.
- Latency from capture to the MSB appearing on SDout is 2*BCLK_HALF clks, i.e. the next falling event.
- en deasserted mid-frame: the frame is aborted at the next edge and all outputs return to reset values. Re-enable restarts framing exactly as after reset.
- Asynchronous rst asserted mid-frame: outputs go to reset values immediately, without waiting for clk.
- Input changes in the same clk as the capture are taken. The block has no ready/valid backpressure; the upstream stage must hold stable data or use smpl_cap to advance.

## Test plan

- Reset/idle: hold rst = 1, then release with en = 0 for 200 clks -> BCLK, LRCLK, SDout and smpl_cap stay 0; no capture occurs.
- Divider: BCLK_HALF = 4, en = 1.
  - BCLK period is 8 clks with a 50% duty cycle.
  - First smpl_cap is on clk edge 8 after release; the next is on edge 264.
  - LRCLK period is 256 clks.
- Framing: lft_in = 16'hA5C3, rht_in = 16'h8001.
  - Sampling SDout on BCLK rising edges over slots 1..32 (the last being next slot 0) reads 0xA5C3 followed by 0x8001.
  - LRCLK rises with the bit carrying lft[0] (slot 16).
- Hold-off: change lft_in to 16'h1234 two clks after smpl_cap -> the current frame still transmits the old value; 0x1234 appears in the next frame.
- Abort/restart: drop en at slot 10, then raise it 50 clks later -> all outputs are 0 on the next edge; after re-enable the first smpl_cap comes 2*BCLK_HALF clks later and the full word sequence restarts from the MSB.
- Async reset mid-frame: pulse rst between clk edges at slot 20 -> outputs clear without a clk edge; after release the next frame is bit-exact.
